// File: rtl/rgu_output_fifo.sv
// rtl/rgu_output_fifo.sv - Ray output FIFO with drop-on-overflow; optional oAlmostFull via RGU_FIFO_ALMOST_FULL_EN.
module rgu_output_fifo #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iPush,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oData,
  input  logic                  iReady,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oEmpty,
  output logic                  oFull,
  output logic                  oOverflow,
  input  logic                  iClearOverflow
`ifdef RGU_FIFO_ALMOST_FULL_EN
  ,
  output logic                  oAlmostFull
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;

  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_drop;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Status decodes depend only on registered count, never on inputs.
  assign oEmpty    = (r_count == '0);
  assign oFull     = (r_count == CNT_DEPTH);
  assign oValid    = !oEmpty;
  assign oData     = r_mem[r_rd_ptr];
  assign oCount    = r_count;
  assign oOverflow = r_overflow;

  assign w_pop     = oValid & iReady;
  assign w_push_ok = iPush & (!oFull | w_pop);
  assign w_drop    = iPush & !w_push_ok;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_push_ok && w_pop) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  // Storage is intentionally not reset; pointers and count define validity.
  always_ff @(posedge iClock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= iData;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_next;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (iClearOverflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef RGU_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] CNT_AF_LEVEL = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];

  logic r_almost_full;

  assign oAlmostFull = r_almost_full;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_next >= CNT_AF_LEVEL);
    end
  end
`endif

endmodule

// File: tb/tb_rgu_output_fifo.sv
// tb/tb_rgu_output_fifo.sv - Directed self-checking bench for rgu_output_fifo.
module tb_rgu_output_fifo;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iPush = 1'b0;
  logic [31:0] iData = '0;
  logic        oValid;
  logic [31:0] oData;
  logic        iReady = 1'b0;
  logic [4:0]  oCount;
  logic        oEmpty;
  logic        oFull;
  logic        oOverflow;
  logic        iClearOverflow = 1'b0;
`ifdef RGU_FIFO_ALMOST_FULL_EN
  logic        oAlmostFull;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  rgu_output_fifo dut (
    .iClock         (iClock),
    .iReset         (iReset),
    .iPush          (iPush),
    .iData          (iData),
    .oValid         (oValid),
    .oData          (oData),
    .iReady         (iReady),
    .oCount         (oCount),
    .oEmpty         (oEmpty),
    .oFull          (oFull),
    .oOverflow      (oOverflow),
    .iClearOverflow (iClearOverflow)
`ifdef RGU_FIFO_ALMOST_FULL_EN
    ,
    .oAlmostFull    (oAlmostFull)
`endif
  );

  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(oValid), 32'd0);
    check({tag, "_empty"}, 32'(oEmpty), 32'd1);
    check({tag, "_full"}, 32'(oFull), 32'd0);
    check({tag, "_ovf"}, 32'(oOverflow), 32'd0);
    check({tag, "_count"}, 32'(oCount), 32'd0);
`ifdef RGU_FIFO_ALMOST_FULL_EN
    check({tag, "_af"}, 32'(oAlmostFull), 32'd0);
`endif
  endtask

  initial begin
    step();
    step();
    check_reset_state("rst");
    iReset = 1'b1;
    step();

    // Five words, then drain in order
    for (int i = 1; i <= 5; i++) begin
      iPush = 1'b1; iData = 32'(i);
      step();
    end
    iPush = 1'b0;
    check("t1_count", 32'(oCount), 32'd5);
    check("t1_valid", 32'(oValid), 32'd1);
    check("t1_head", oData, 32'h1);
    iReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("t1_pop", oData, 32'(i));
      step();
    end
    iReady = 1'b0;
    check("t1_empty", 32'(oEmpty), 32'd1);
    check("t1_count0", 32'(oCount), 32'd0);

    // Fill, overflow, clear-vs-set priority, drain
    for (int i = 0; i < 16; i++) begin
      iPush = 1'b1; iData = 32'hA0 + 32'(i);
      step();
    end
    check("t2_full", 32'(oFull), 32'd1);
    check("t2_count", 32'(oCount), 32'd16);
    check("t2_ovf0", 32'(oOverflow), 32'd0);
    iData = 32'hBB;
    step();
    check("t2_ovf", 32'(oOverflow), 32'd1);
    check("t2_count_ovf", 32'(oCount), 32'd16);
    iClearOverflow = 1'b1;
    step();
    check("t5_set_wins", 32'(oOverflow), 32'd1);
    check("t5_count", 32'(oCount), 32'd16);
    iPush = 1'b0;
    step();
    iClearOverflow = 1'b0;
    check("t5_cleared", 32'(oOverflow), 32'd0);
    iReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_pop", oData, 32'hA0 + 32'(i));
      step();
    end
    iReady = 1'b0;
    check("t2_empty", 32'(oEmpty), 32'd1);
    check("t2_valid0", 32'(oValid), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      iPush = 1'b1; iData = 32'h10 + 32'(i);
      step();
    end
    iPush = 1'b1; iData = 32'hCC; iReady = 1'b1;
    check("t3_head", oData, 32'h10);
    step();
    iPush = 1'b0;
    check("t3_count", 32'(oCount), 32'd16);
    check("t3_ovf", 32'(oOverflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      check("t3_pop", oData, 32'h10 + 32'(i));
      step();
    end
    check("t3_last", oData, 32'hCC);
    step();
    iReady = 1'b0;
    check("t3_empty", 32'(oEmpty), 32'd1);

    // Streaming through pointer wrap
    iPush = 1'b1; iData = 32'd0;
    step();
    iReady = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      iData = 32'(k);
      check("t4_count", 32'(oCount), 32'd1);
      check("t4_data", oData, 32'(k - 1));
      step();
    end
    iPush = 1'b0;
    check("t4_tail", oData, 32'd40);
    step();
    iReady = 1'b0;
    check("t4_empty", 32'(oEmpty), 32'd1);

`ifdef RGU_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 11; i++) begin
      iPush = 1'b1; iData = 32'h300 + 32'(i);
      step();
    end
    check("af_11", 32'(oAlmostFull), 32'd0);
    iData = 32'h30B;
    step();
    iPush = 1'b0;
    check("af_12", 32'(oAlmostFull), 32'd1);
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    check("af_pop", 32'(oAlmostFull), 32'd0);
    check("af_count", 32'(oCount), 32'd11);
    iReady = 1'b1;
    for (int i = 1; i < 12; i++) begin
      check("af_drain", oData, 32'h300 + 32'(i));
      step();
    end
    iReady = 1'b0;
`endif

    // Asynchronous reset mid-fill
    for (int i = 0; i < 6; i++) begin
      iPush = 1'b1; iData = 32'h500 + 32'(i);
      step();
    end
    iPush = 1'b0;
    iData = 32'hBB;
    iPush = 1'b1;
    check("ar_pre_count", 32'(oCount), 32'd6);
    #1;
    iReset = 1'b0;
    #1;
    check_reset_state("ar");
    iPush = 1'b0;
    step();
    check_reset_state("ar_hold");
    iReset = 1'b1;
    step();
    iPush = 1'b1; iData = 32'h77;
    step();
    iPush = 1'b0;
    check("ar_after_count", 32'(oCount), 32'd1);
    check("ar_after_data", oData, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
